// File: rtl/barker_pkg.sv
// Shared types and helpers for the Barker stimulus generator: FSM states,
// code lookup, LFSR polynomial and next-state function.
package barker_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_PAUSE
    } state_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic bit is_legal_len(input int len);
        return len inside {2, 3, 4, 5, 7, 11, 13};
    endfunction

    // Code right-aligned, first transmitted chip in bit len-1.
    function automatic logic [12:0] barker_code(input int len);
        case (len)
            2:       return 13'b10;
            3:       return 13'b110;
            4:       return 13'b1101;
            5:       return 13'b11101;
            7:       return 13'b1110010;
            11:      return 13'b11100010010;
            13:      return 13'b1111100110101;
            default: return '0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/barker_stim_gen_if.sv
// AXI-Stream style symbol channel between the generator and its consumer.
interface barker_stim_gen_if #(
    parameter int DATA_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR advancing one step per i_step pulse.
module lfsr16
    import barker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    // NOTE: registered state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_state <= i_seed;
        end else if (i_step) begin
            o_state <= lfsr_step(o_state);
        end
    end

endmodule

// File: rtl/barker_stim_gen.sv
// Barker-code frame generator with pseudo-random inter-frame gaps and
// optional single-chip error injection on an AXI-Stream style output.
module barker_stim_gen
    import barker_pkg::*;
#(
    parameter int          CODE_LEN  = 11,
    parameter int          DATA_W    = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [7:0]          i_pause_min,
    input  logic [7:0]          i_pause_max,
    input  logic                i_err_en,
    barker_stim_gen_if.master   m_axis,
    output logic [31:0]         o_frame_cnt,
    output logic [31:0]         o_err_cnt
);

    if (!is_legal_len(CODE_LEN)) begin : g_bad_len
        $error("barker_stim_gen: illegal CODE_LEN %0d", CODE_LEN);
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("barker_stim_gen: LFSR_SEED must be non-zero");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("barker_stim_gen: DATA_W must be at least 1");
    end

    localparam int              K         = $clog2(2 * CODE_LEN);
    localparam logic [12:0]     CODE      = barker_code(CODE_LEN);
    localparam int              SYM_SHIFT = (DATA_W >= 2) ? DATA_W - 2 : 0;
    localparam logic [DATA_W-1:0] SYM_POS = DATA_W'(1) << SYM_SHIFT;
    localparam logic [DATA_W-1:0] SYM_NEG = -SYM_POS;

    typedef struct packed {
        logic [7:0] pause;
        logic       err_on;
        logic [3:0] err_idx;
    } frame_cfg_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              user;
    } beat_t;

    function automatic frame_cfg_t plan_frame(input logic [15:0] s, input logic [7:0] pmin,
                                              input logic [7:0] pmax, input logic err_en);
        frame_cfg_t c;
        logic [7:0]   span;
        logic [15:0]  prod;
        logic [K-1:0] idx;
        span      = (pmax >= pmin) ? pmax - pmin : 8'd0;
        prod      = 16'(s[15:8]) * (16'(span) + 16'd1);
        c.pause   = pmin + 8'(prod >> 8);
        idx       = s[K-1:0];
        c.err_on  = err_en && (int'(idx) < CODE_LEN);
        c.err_idx = 4'(idx);
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] symbol(input logic b);
        if (DATA_W == 1) return DATA_W'(b);
        return b ? SYM_POS : SYM_NEG;
    endfunction

    function automatic beat_t make_beat(input logic [3:0] b, input frame_cfg_t c);
        beat_t r;
        logic  flip;
        flip   = c.err_on && (b == c.err_idx);
        r.data = symbol(CODE[CODE_LEN-1-int'(b)] ^ flip);
        r.last = (int'(b) == CODE_LEN - 1);
        r.user = flip;
        return r;
    endfunction

    state_t      state;
    logic [3:0]  beat;
    logic [7:0]  pause_cnt;
    frame_cfg_t  cfg;
    frame_cfg_t  plan;
    beat_t       out_q;
    logic        tvalid_q;
    logic        accept;
    logic        lfsr_step_en;
    logic [15:0] lfsr_q;

    assign accept       = tvalid_q && m_axis.tready;
    assign lfsr_step_en = (state == S_GEN) && accept && out_q.last;

    lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (lfsr_step_en),
        .i_seed  (LFSR_SEED),
        .o_state (lfsr_q)
    );

    // From idle the current LFSR value plans the first frame; at tlast the
    // value it is about to step to plans the gap and the following frame.
    always_comb begin
        plan = plan_frame((state == S_IDLE) ? lfsr_q : lfsr_step(lfsr_q),
                          i_pause_min, i_pause_max, i_err_en);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            beat        <= '0;
            pause_cnt   <= '0;
            cfg         <= '0;
            out_q       <= '0;
            tvalid_q    <= 1'b0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state    <= S_GEN;
                        beat     <= '0;
                        cfg      <= plan;
                        out_q    <= make_beat(4'd0, plan);
                        tvalid_q <= 1'b1;
                    end
                end
                S_GEN: begin
                    if (accept && !out_q.last) begin
                        beat  <= beat + 4'd1;
                        out_q <= make_beat(beat + 4'd1, cfg);
                    end else if (accept) begin
                        o_frame_cnt <= o_frame_cnt + 32'd1;
                        if (cfg.err_on) o_err_cnt <= o_err_cnt + 32'd1;
                        cfg  <= plan;
                        beat <= '0;
                        if (plan.pause != 8'd0) begin
                            state     <= S_PAUSE;
                            pause_cnt <= plan.pause;
                            tvalid_q  <= 1'b0;
                        end else if (i_enable) begin
                            out_q <= make_beat(4'd0, plan);
                        end else begin
                            state    <= S_IDLE;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (pause_cnt == 8'd1) begin
                        if (i_enable) begin
                            state    <= S_GEN;
                            out_q    <= make_beat(4'd0, cfg);
                            tvalid_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        pause_cnt <= pause_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = out_q.data;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_barker_stim_gen.sv
// Scoreboard bench for barker_stim_gen: one 11-chip bit generator and one
// 13-chip 8-bit antipodal generator sharing clock, reset and gap controls.
module tb_barker_stim_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic [7:0] pmin, pmax;
    logic       err_en;
    logic       rdy;
    logic [31:0] fc_a, ec_a, fc_b, ec_b;

    always #5 clk = ~clk;

    barker_stim_gen_if #(.DATA_W(1)) a_if ();
    barker_stim_gen_if #(.DATA_W(8)) b_if ();

    assign a_if.tready = rdy;
    assign b_if.tready = rdy;

    barker_stim_gen #(.CODE_LEN(11), .DATA_W(1), .LFSR_SEED(SEED)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_enable(en_a), .i_pause_min(pmin), .i_pause_max(pmax),
        .i_err_en(err_en), .m_axis(a_if), .o_frame_cnt(fc_a), .o_err_cnt(ec_a)
    );

    barker_stim_gen #(.CODE_LEN(13), .DATA_W(8), .LFSR_SEED(SEED)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_enable(en_b), .i_pause_min(pmin), .i_pause_max(pmax),
        .i_err_en(err_en), .m_axis(b_if), .o_frame_cnt(fc_b), .o_err_cnt(ec_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sel     = 1'b0;
    logic [15:0] m_lfsr [2];
    int          m_frames [2];
    int          m_errs [2];
    int          flagged;
    exp_t        exp_q [$];
    int          gap_q [$];

    // ---------------- observation and reference model ----------------
    function automatic logic       obs_valid(); return sel ? b_if.tvalid : a_if.tvalid; endfunction
    function automatic logic       obs_last();  return sel ? b_if.tlast  : a_if.tlast;  endfunction
    function automatic logic       obs_user();  return sel ? b_if.tuser  : a_if.tuser;  endfunction
    function automatic logic [7:0] obs_data();  return sel ? b_if.tdata  : {7'b0, a_if.tdata}; endfunction
    function automatic logic [31:0] obs_fc();   return sel ? fc_b : fc_a; endfunction
    function automatic logic [31:0] obs_ec();   return sel ? ec_b : ec_a; endfunction
    function automatic int          code_len(); return sel ? 13 : 11; endfunction

    function automatic logic code_bit(input int b);
        logic [12:0] c;
        c = sel ? 13'b1111100110101 : 13'b0011100010010;
        return c[code_len() - 1 - b];
    endfunction

    function automatic logic [7:0] sym(input logic b);
        if (sel) return b ? 8'd64 : 8'hC0;
        return {7'b0, b};
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int m_pause(input logic [15:0] s);
        int span;
        span = (pmax >= pmin) ? int'(pmax) - int'(pmin) : 0;
        return int'(pmin) + ((int'(s[15:8]) * (span + 1)) >> 8);
    endfunction

    task automatic push_frame();
        int   idx;
        bit   err;
        exp_t e;
        logic b;
        idx = int'(m_lfsr[sel][4:0]);
        err = err_en && (idx < code_len());
        for (int i = 0; i < code_len(); i++) begin
            b      = code_bit(i) ^ (err && i == idx);
            e.data = sym(b);
            e.last = (i == code_len() - 1);
            e.user = err && (i == idx);
            exp_q.push_back(e);
        end
        if (err) m_errs[sel]++;
        m_frames[sel]++;
        m_lfsr[sel] = m_step(m_lfsr[sel]);
        gap_q.push_back(m_pause(m_lfsr[sel]));
    endtask

    task automatic set_en(input logic v);
        if (sel) en_b = v; else en_a = v;
    endtask

    // Runs n frames, stalling beat stall_beat of frame 0 for 3 cycles and
    // dropping enable at beat drop_beat of the last frame, then checks idling.
    task automatic run_frames(input int n, input int stall_beat, input int drop_beat,
                              input string tag);
        int   cl, budget, cyc, b, gap, hd, flip_pos, upos, busy;
        exp_t e;
        logic [7:0] hd_data;
        logic hd_last, hd_user;
        logic [31:0] hd_fc;
        cl = code_len();
        budget = n * (cl + 270) + 50;
        cyc = 0;
        exp_q.delete();
        gap_q.delete();
        @(negedge clk);
        set_en(1'b1);
        for (int f = 0; f < n; f++) begin
            push_frame();
            b = 0; gap = 0; hd = 0; flip_pos = -1; upos = -1;
            while (b < cl) begin
                @(negedge clk);
                cyc++;
                if (cyc > budget) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s timeout: frame %0d beat %0d not reached in %0d cycles",
                             tag, f, b, budget);
                    set_en(1'b0);
                    return;
                end
                if (!obs_valid()) begin
                    if (b > 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL %s bubble: tvalid=0 inside frame %0d at beat %0d", tag, f, b);
                    end
                    gap++;
                    continue;
                end
                if (f == 0 && b == stall_beat) begin
                    rdy = 1'b0;
                    hd_data = obs_data(); hd_last = obs_last(); hd_user = obs_user(); hd_fc = obs_fc();
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        cyc++;
                        n_tests++;
                        if ({obs_valid(), obs_data(), obs_last(), obs_user(), obs_fc()} !==
                            {1'b1, hd_data, hd_last, hd_user, hd_fc}) begin
                            n_fail++;
                            $display("FAIL %s stall_hold: got v=%0b d=%0h l=%0b u=%0b fc=%0d required v=1 d=%0h l=%0b u=%0b fc=%0d",
                                     tag, obs_valid(), obs_data(), obs_last(), obs_user(), obs_fc(),
                                     hd_data, hd_last, hd_user, hd_fc);
                        end
                    end
                    rdy = 1'b1;
                end
                if (f == n - 1 && b == drop_beat) set_en(1'b0);
                if (b == 0 && f > 0) begin
                    n_tests++;
                    if (gap !== gap_q[0]) begin
                        n_fail++;
                        $display("FAIL %s gap: frame %0d got %0d idle cycles required %0d",
                                 tag, f, gap, gap_q[0]);
                    end
                    void'(gap_q.pop_front());
                end
                e = exp_q.pop_front();
                n_tests++;
                if ({obs_data(), obs_last(), obs_user()} !== {e.data, e.last, e.user}) begin
                    n_fail++;
                    $display("FAIL %s beat: frame %0d beat %0d got d=%0h l=%0b u=%0b required d=%0h l=%0b u=%0b",
                             tag, f, b, obs_data(), obs_last(), obs_user(), e.data, e.last, e.user);
                end
                if (obs_data() !== sym(code_bit(b))) begin hd++; flip_pos = b; end
                if (obs_user()) upos = b;
                b++;
            end
            n_tests++;
            if (hd > 1 || flip_pos != upos) begin
                n_fail++;
                $display("FAIL %s hamming: frame %0d distance %0d flipped beat %0d tuser beat %0d",
                         tag, f, hd, flip_pos, upos);
            end
            if (upos >= 0) flagged++;
        end
        busy = 0;
        for (int i = 0; i < 270; i++) begin
            @(negedge clk);
            if (obs_valid()) busy++;
        end
        n_tests++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL %s idle: tvalid high %0d cycles after enable dropped, required 0", tag, busy);
        end
        n_tests++;
        if (obs_fc() !== 32'(m_frames[sel])) begin
            n_fail++;
            $display("FAIL %s frame_cnt: got %0d required %0d", tag, obs_fc(), m_frames[sel]);
        end
        n_tests++;
        if (obs_ec() !== 32'(m_errs[sel])) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d required %0d", tag, obs_ec(), m_errs[sel]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy = 1'b1;
        pmin = 8'd0; pmax = 8'd0; err_en = 1'b0;
        m_lfsr[0] = SEED; m_lfsr[1] = SEED;
        m_frames[0] = 0; m_frames[1] = 0; m_errs[0] = 0; m_errs[1] = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_if.tvalid, a_if.tlast, a_if.tuser, a_if.tdata} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got %b required 0000",
                     {a_if.tvalid, a_if.tlast, a_if.tuser, a_if.tdata});
        end
        n_tests++;
        if ({b_if.tvalid, b_if.tlast, b_if.tuser, b_if.tdata} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got %b required 0", {b_if.tvalid, b_if.tlast, b_if.tuser, b_if.tdata});
        end
        n_tests++;
        if ({fc_a, ec_a, fc_b, ec_b} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d required 0 0 0 0", fc_a, ec_a, fc_b, ec_b);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_if.tvalid, b_if.tvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: tvalid a=%0b b=%0b required 0 0", a_if.tvalid, b_if.tvalid);
        end
    endtask

    task automatic test_continuous();
        sel = 1'b0; pmin = 8'd0; pmax = 8'd0; err_en = 1'b0;
        run_frames(3, -1, 10, "continuous");
    endtask

    task automatic test_stall();
        sel = 1'b0;
        run_frames(1, 4, 10, "stall");
    endtask

    task automatic test_pause();
        sel = 1'b0; err_en = 1'b0;
        pmin = 8'd5; pmax = 8'd5;
        run_frames(4, -1, 10, "pause_5_5");
        pmin = 8'd3; pmax = 8'd1;
        run_frames(4, -1, 10, "pause_3_1");
    endtask

    task automatic test_errors();
        sel = 1'b0; err_en = 1'b1; pmin = 8'd0; pmax = 8'd3;
        flagged = 0;
        run_frames(200, -1, 10, "errors");
        n_tests++;
        if (ec_a !== 32'(flagged) || flagged == 0) begin
            n_fail++;
            $display("FAIL err_flagged: err_cnt %0d flagged frames %0d (required equal and non-zero)",
                     ec_a, flagged);
        end
        err_en = 1'b0;
    endtask

    task automatic test_symbols();
        sel = 1'b1; err_en = 1'b0; pmin = 8'd0; pmax = 8'd0;
        run_frames(3, -1, 12, "symbols13");
        sel = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int acc, cyc;
        sel = 1'b0; err_en = 1'b1; pmin = 8'd0; pmax = 8'd2;
        acc = 0; cyc = 0;
        @(negedge clk);
        en_a = 1'b1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (a_if.tvalid) begin
                if (acc == 6) break;
                acc++;
            end
        end
        n_tests++;
        if (acc !== 6) begin
            n_fail++;
            $display("FAIL reset_reach_beat6: got %0d accepted beats required 6", acc);
        end
        rst = 1'b1;
        en_a = 1'b0;
        #1;
        n_tests++;
        if ({a_if.tvalid, a_if.tlast, a_if.tuser, a_if.tdata, fc_a, ec_a} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_midframe_outputs: got v=%0b l=%0b u=%0b d=%0b fc=%0d ec=%0d required all 0",
                     a_if.tvalid, a_if.tlast, a_if.tuser, a_if.tdata, fc_a, ec_a);
        end
        @(negedge clk);
        rst = 1'b0;
        m_lfsr[0] = SEED; m_lfsr[1] = SEED;
        m_frames[0] = 0; m_frames[1] = 0; m_errs[0] = 0; m_errs[1] = 0;
        run_frames(3, -1, 10, "post_reset");
        err_en = 1'b0;
    endtask

    task automatic test_enable_drop();
        sel = 1'b0; pmin = 8'd1; pmax = 8'd4;
        run_frames(2, -1, 5, "enable_drop");
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_stall();
        test_pause();
        test_errors();
        test_symbols();
        test_reset_midframe();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
